stream_in_fifo: RTL and testbench
=================================

// Module: stream_in_fifo
// PURPOSE
//  Per-source elastic buffer placed upstream of the stream crossbar: one instance per s_* port.
//  Stores beats (data, dest, last) in a first-word-fall-through FIFO.
//  Decouples the source from arbitration stalls and holds s_dest stable for the whole packet.
// PARAMETERS
//  T_DATA_WIDTH  8  width of data beat
//  T_DEST_WIDTH  2  width of destination index (crossbar M_DATA_COUNT encoding)
//  DEPTH         4  entries; power of two, >= 2
// PORTS
//  clk_i      in   1                     clock
//  rst_in     in   1                     asynchronous active-low reset
//  s_data_i   in   T_DATA_WIDTH          upstream beat data
//  s_dest_i   in   T_DEST_WIDTH          upstream destination
//  s_last_i   in   1                     upstream end-of-packet
//  s_valid_i  in   1                     upstream valid
//  s_ready_o  out  1                     space available
//  m_data_o   out  T_DATA_WIDTH          head beat data to crossbar
//  m_dest_o   out  T_DEST_WIDTH          head beat destination
//  m_last_o   out  1                     head beat end-of-packet
//  m_valid_o  out  1                     head beat valid
//  m_ready_i  in   1                     crossbar accepts head beat
//  count_o    out  $clog2(DEPTH+1)       current occupancy
// BEHAVIOUR
//  - Reset (rst_in low, async assert, sync deassert): pointers=0, count_o=0, m_valid_o=0,
//    s_ready_o=0 while in reset, 1 from first clock after release. m_data/dest/last don't-care while m_valid_o=0.
//  - Write when s_valid_i & s_ready_o; read when m_valid_o & m_ready_i; both on same edge allowed.
//  - s_ready_o = (count != DEPTH); depends only on registered state, never on m_ready_i.
//  - Full + read in same cycle: no write that cycle (s_ready_o already low); space appears next cycle.
//  - Latency: beat written at edge N is visible on m_* after edge N (m_valid_o high in cycle N+1). No empty bypass.
//  - m_* outputs driven from storage at read pointer; stable while m_valid_o & !m_ready_i.
//  - Pointers $clog2(DEPTH)+1 bits; wrap naturally; full = MSBs differ, LSBs equal; empty = equal.
//  - count_o: +1 on write only, -1 on read only, unchanged on both/neither; range 0..DEPTH.
//  - Dest lock: dest is sampled on the first beat of a packet (after reset or after a beat with last=1).
//    Later beats of that packet store the locked dest, ignoring s_dest_i. This guarantees the crossbar arbiter
//    sees one dest per packet.
// CONFIGURATION
//  STREAM_IN_FIFO_PKT_MODE_EN defined: store-and-forward.
//  - pkt_cnt register counts stored beats with last=1: +1 on write of last, -1 on read of last.
//  - m_valid_o = !empty & (pkt_cnt != 0 | full).
//  - The full override is cut-through fallback for packets longer than DEPTH (prevents deadlock).
//  - Simultaneous write-last and read-last leave pkt_cnt unchanged. pkt_cnt resets to 0.
//  Undefined: cut-through; m_valid_o = !empty.
// STRUCTURE
//  - stream_xbar_pkg: pointer/count width functions (ptr_w(DEPTH), cnt_w(DEPTH)) and the packed beat
//    struct builder {last, dest, data} width localparam.
//  - Sub-module stream_fifo_mem: DEPTH x (T_DATA_WIDTH+T_DEST_WIDTH+1) register array.
//    Has a synchronous write port and an asynchronous read port, with no reset on storage.
//  - Top module holds the pointers, count, dest lock and optional pkt_cnt.
// TESTING
//  1 Reset mid-transfer: fill 3 beats, pull rst_in low -> m_valid_o=0, count_o=0 immediately;
//    after release first write of 0xA5 appears on m_data_o next cycle.
//  2 Fill DEPTH=4 with m_ready_i=0 -> s_ready_o low after 4th write, count_o=4;
//    drain with m_ready_i=1 -> data out 0x01,0x02,0x03,0x04 in order, count_o returns to 0.
//  3 Full with s_valid_i=1, m_ready_i=1 one cycle -> one read, no write, count_o=3; write accepted next cycle.
//  4 Dest lock: packet dest=2 first beat, later beats s_dest_i=1, last on beat 3 -> all 3 beats m_dest_o=2;
//    next packet dest=1 -> m_dest_o=1.
//  5 Continuous stream with random m_ready_i back-pressure, 1000 beats -> scoreboard exact order,
//    no loss or duplication, count_o never > 4.
//  6 PKT_MODE_EN: 3-beat packet with last withheld -> m_valid_o stays 0; last written -> m_valid_o=1 next cycle.
//    A 6-beat packet into DEPTH=4 -> m_valid_o rises at full and all beats drain.

Source files
------------

// File: rtl/stream_xbar_pkg.sv
// Shared sizing helpers for the stream crossbar input buffers.
// Pointer, occupancy and stored-beat widths are derived from the buffer
// parameters here, so every user of the package sizes its state the same way.
package stream_xbar_pkg;

    // Read/write pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Occupancy counter width: must be able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of one stored beat, packed as {last, dest, data}.
    function automatic int beat_w(input int data_w, input int dest_w);
        return data_w + dest_w + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Storage array for stream_in_fifo.
// Synchronous write port and asynchronous read port, so the head entry is
// visible in the same cycle the read pointer points at it.
module stream_fifo_mem #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming beat at the write address.
    // NOTE: storage has no reset; validity is tracked by the pointers, so
    // stale contents are never observed and the array maps onto plain flops/RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_in_fifo.sv
// Per-source elastic buffer in front of the stream crossbar.
// First-word-fall-through FIFO of {last, dest, data} beats. The destination
// is captured on the first beat of each packet and reused for the rest of
// the packet, so the arbiter never sees the destination change mid-packet.
// Optional build macro STREAM_IN_FIFO_PKT_MODE_EN selects store-and-forward:
// the head is only offered once a complete packet is stored, or when the
// buffer is full (cut-through fallback for packets longer than DEPTH).
module stream_in_fifo
    import stream_xbar_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DEST_WIDTH = 2,
    parameter int DEPTH        = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_in,
    input  logic [T_DATA_WIDTH-1:0]       s_data_i,
    input  logic [T_DEST_WIDTH-1:0]       s_dest_i,
    input  logic                          s_last_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic [T_DATA_WIDTH-1:0]       m_data_o,
    output logic [T_DEST_WIDTH-1:0]       m_dest_o,
    output logic                          m_last_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam int ADDR_W = PTR_W - 1;
    localparam int BEAT_W = beat_w(T_DATA_WIDTH, T_DEST_WIDTH);

    typedef struct packed {
        logic                    last;
        logic [T_DEST_WIDTH-1:0] dest;
        logic [T_DATA_WIDTH-1:0] data;
    } beat_t;

    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    active;
    logic                    in_pkt;
    logic [T_DEST_WIDTH-1:0] lock_dest;
    logic                    empty;
    logic                    full;
    logic                    wr_en;
    logic                    rd_en;
    beat_t                   wr_beat;
    beat_t                   head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // Ready comes only from registered state and stays low until the first
    // clock after reset release.
    assign s_ready_o = active && (count != CNT_W'(DEPTH));
    assign wr_en     = s_valid_i && s_ready_o;
    assign rd_en     = m_valid_o && m_ready_i;
    assign count_o   = count;

    // Beats after the first of a packet carry the locked destination.
    always_comb begin
        wr_beat.data = s_data_i;
        wr_beat.last = s_last_i;
        wr_beat.dest = in_pkt ? lock_dest : s_dest_i;
    end

    stream_fifo_mem #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (head)
    );

    assign m_data_o = head.data;
    assign m_dest_o = head.dest;
    assign m_last_o = head.last;

    // Marks the buffer as out of reset one clock after rst_in releases.
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    // Advance pointers and occupancy on accepted writes and reads.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Track packet boundaries and hold the destination of the open packet.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            in_pkt    <= 1'b0;
            lock_dest <= '0;
        end else if (wr_en) begin
            in_pkt <= !s_last_i;
            if (!in_pkt) begin
                lock_dest <= s_dest_i;
            end
        end
    end

`ifdef STREAM_IN_FIFO_PKT_MODE_EN
    logic [CNT_W-1:0] pkt_cnt;

    // Count complete packets held in the buffer.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            pkt_cnt <= '0;
        end else begin
            case ({wr_en && s_last_i, rd_en && m_last_o})
                2'b10:   pkt_cnt <= pkt_cnt + CNT_W'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CNT_W'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // Offer the head once a whole packet is stored, or when full so long
    // packets cut through instead of deadlocking.
    assign m_valid_o = !empty && ((pkt_cnt != '0) || full);
`else
    // Cut-through: any stored beat is offered immediately.
    assign m_valid_o = !empty;
`endif

endmodule

// File: tb/tb_stream_in_fifo.sv
// Self-checking bench for stream_in_fifo (DEPTH=4, 8-bit data, 2-bit dest).
// Define STREAM_IN_FIFO_PKT_MODE_EN to also exercise store-and-forward mode.
module tb_stream_in_fifo;

    logic       clk_i = 1'b0;
    logic       rst_in;
    logic [7:0] s_data_i;
    logic [1:0] s_dest_i;
    logic       s_last_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic [7:0] m_data_o;
    logic [1:0] m_dest_o;
    logic       m_last_o;
    logic       m_valid_o;
    logic       m_ready_i;
    logic [2:0] count_o;

    int n_cmp = 0;
    int n_err = 0;

    stream_in_fifo #(
        .T_DATA_WIDTH (8),
        .T_DEST_WIDTH (2),
        .DEPTH        (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_in    (rst_in),
        .s_data_i  (s_data_i),
        .s_dest_i  (s_dest_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_dest_o  (m_dest_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .count_o   (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] data, input logic [1:0] dest, input logic last);
        s_valid_i = 1'b1;
        s_data_i  = data;
        s_dest_i  = dest;
        s_last_i  = last;
        tick();
        s_valid_i = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] data, input logic [1:0] dest);
        check({tag, "_valid"}, m_valid_o, 1);
        check({tag, "_data"}, m_data_o, data);
        check({tag, "_dest"}, m_dest_o, dest);
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
    endtask

    logic [9:0] sb[$];

    initial begin
        rst_in = 1'b0; s_valid_i = 1'b0; s_data_i = '0; s_dest_i = '0;
        s_last_i = 1'b0; m_ready_i = 1'b0;

        // ---- Reset state and release
        #12;
        check("rst_count", count_o, 0);
        check("rst_valid", m_valid_o, 0);
        check("rst_ready", s_ready_o, 0);
        rst_in = 1'b1;
        tick();
        check("rel_ready", s_ready_o, 1);

        // ---- Test 1: reset mid-transfer
        push(8'h01, 2'd0, 1'b1);
        push(8'h02, 2'd0, 1'b1);
        push(8'h03, 2'd0, 1'b1);
        check("t1_count3", count_o, 3);
        #2 rst_in = 1'b0;
        #1;
        check("t1_rst_valid", m_valid_o, 0);
        check("t1_rst_count", count_o, 0);
        check("t1_rst_ready", s_ready_o, 0);
        #2 rst_in = 1'b1;
        tick();
        check("t1_rel_ready", s_ready_o, 1);
        check("t1_rel_valid", m_valid_o, 0);
        push(8'hA5, 2'd3, 1'b1);
        check("t1_a5_count", count_o, 1);
        pop_check("t1_a5", 8'hA5, 2'd3);
        check("t1_empty", m_valid_o, 0);

        // ---- Test 2: fill to DEPTH then drain in order
        for (int i = 1; i <= 4; i++) begin
            check("t2_ready_pre", s_ready_o, 1);
            push(8'(i), 2'd1, 1'b1);
        end
        check("t2_full_ready", s_ready_o, 0);
        check("t2_full_count", count_o, 4);
        for (int i = 1; i <= 4; i++) begin
            pop_check("t2_drain", 8'(i), 2'd1);
        end
        check("t2_end_count", count_o, 0);
        check("t2_end_valid", m_valid_o, 0);

        // ---- Test 3: full with simultaneous valid and ready
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 2'd0, 1'b1);
        s_valid_i = 1'b1; s_data_i = 8'h20; s_dest_i = 2'd2; s_last_i = 1'b1;
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        check("t3_count_after", count_o, 3);
        check("t3_head", m_data_o, 8'h11);
        check("t3_ready_back", s_ready_o, 1);
        tick();
        s_valid_i = 1'b0;
        check("t3_count_refill", count_o, 4);
        pop_check("t3_d0", 8'h11, 2'd0);
        pop_check("t3_d1", 8'h12, 2'd0);
        pop_check("t3_d2", 8'h13, 2'd0);
        pop_check("t3_d3", 8'h20, 2'd2);

        // ---- Test 4: destination lock across a packet
        push(8'h31, 2'd2, 1'b0);
        push(8'h32, 2'd1, 1'b0);
        push(8'h33, 2'd1, 1'b1);
        push(8'h34, 2'd1, 1'b1);
        pop_check("t4_b0", 8'h31, 2'd2);
        check("t4_b0_last", m_last_o, 0);
        pop_check("t4_b1", 8'h32, 2'd2);
        check("t4_b2_last", m_last_o, 1);
        pop_check("t4_b2", 8'h33, 2'd2);
        pop_check("t4_next", 8'h34, 2'd1);

        // ---- Test 5: random back-pressure stream, scoreboard model
        begin
            int sent = 0;
            int rcvd = 0;
            int cyc  = 0;
            int mcnt = 0;
            int errs_before = n_err;
            bit w, r;
            logic [9:0] beat;
            while (rcvd < 1000 && cyc < 20000) begin
                s_valid_i = (sent < 1000) && ($urandom_range(3) != 0);
                beat      = 10'($urandom);
                s_data_i  = beat[7:0];
                s_dest_i  = beat[9:8];
                s_last_i  = 1'b1;
                m_ready_i = ($urandom_range(2) != 0);
                #0;
                if ((s_ready_o !== (mcnt != 4)) || (m_valid_o !== (mcnt != 0)) ||
                    (count_o !== 3'(mcnt))) begin
                    check("t5_ready", s_ready_o, mcnt != 4);
                    check("t5_valid", m_valid_o, mcnt != 0);
                    check("t5_count", count_o, mcnt);
                end
                w = s_valid_i && (mcnt != 4);
                r = m_ready_i && (mcnt != 0);
                if (r) begin
                    check("t5_beat", {m_dest_o, m_data_o}, sb.pop_front());
                    rcvd++;
                end
                if (w) begin
                    sb.push_back(beat);
                    sent++;
                end
                mcnt = mcnt + int'(w) - int'(r);
                tick();
                cyc++;
            end
            s_valid_i = 1'b0; m_ready_i = 1'b0;
            check("t5_received", rcvd, 1000);
            check("t5_no_errs", n_err - errs_before, 0);
            check("t5_final_count", count_o, 0);
        end

`ifdef STREAM_IN_FIFO_PKT_MODE_EN
        // ---- Test 6: store-and-forward gating
        push(8'h61, 2'd1, 1'b0);
        check("t6_hold0", m_valid_o, 0);
        push(8'h62, 2'd1, 1'b0);
        check("t6_hold1", m_valid_o, 0);
        tick();
        tick();
        check("t6_hold2", m_valid_o, 0);
        push(8'h63, 2'd1, 1'b1);
        check("t6_release", m_valid_o, 1);
        pop_check("t6_p0", 8'h61, 2'd1);
        pop_check("t6_p1", 8'h62, 2'd1);
        pop_check("t6_p2", 8'h63, 2'd1);
        check("t6_empty", m_valid_o, 0);
        for (int i = 0; i < 4; i++) begin
            push(8'h71 + 8'(i), 2'd3, 1'b0);
            check("t6_long_valid", m_valid_o, (i == 3) ? 1 : 0);
        end
        begin
            int nxt = 4;
            int got = 0;
            bit w, r;
            m_ready_i = 1'b1;
            for (int c = 0; c < 50 && got < 6; c++) begin
                s_valid_i = (nxt < 6);
                s_data_i  = 8'h71 + 8'(nxt);
                s_dest_i  = 2'd0;
                s_last_i  = (nxt == 5);
                #0;
                w = s_valid_i && s_ready_o;
                r = m_valid_o && m_ready_i;
                if (r) begin
                    check("t6_long_data", m_data_o, 8'h71 + 8'(got));
                    check("t6_long_dest", m_dest_o, 2'd3);
                    got++;
                end
                if (w) nxt++;
                tick();
            end
            s_valid_i = 1'b0; m_ready_i = 1'b0;
            check("t6_long_drained", got, 6);
            check("t6_long_count", count_o, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
